// File: rtl/rsp_s1_prep_pg_ctrl.sv
// Sequencing controller for the phase-generation prep stage: loads the entry table, then
// runs fetch/wait/start/run per frame. Optional frame counter under RSP_PG_CTRL_FRAME_CNT_EN.
module rsp_s1_prep_pg_ctrl #(
  parameter int RAM_DELAY       = 2,
  parameter int RAM1_ADDR_WIDTH = 6,
  parameter int ENTRY_NUM       = 32,
  parameter int DATA_NUM        = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_cfg_wr,
  input  logic [31:0]                i_cfg_data,
  output logic                       o_cfg_done,
  input  logic                       i_frame_req,
  input  logic [RAM1_ADDR_WIDTH-1:0] i_frame_entry,
  output logic                       o_frame_ack,
  input  logic                       i_stall,
  output logic                       o_ram1_ena,
  output logic                       o_ram1_wena,
  output logic [RAM1_ADDR_WIDTH-1:0] o_ram1_addr,
  output logic [31:0]                o_ram1_dina,
  output logic                       o_start,
  output logic                       o_data_valid,
  output logic                       o_data_last,
  output logic                       o_busy,
  output logic                       o_err
`ifdef RSP_PG_CTRL_FRAME_CNT_EN
  ,
  output logic [15:0]                o_frame_cnt
`endif
);

  localparam int AW     = RAM1_ADDR_WIDTH;
  localparam int BEATS  = DATA_NUM / 4;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DLY_W  = (RAM_DELAY > 1) ? $clog2(RAM_DELAY) : 1;
  localparam logic [AW:0]       ENTRY_CNT = (AW+1)'(ENTRY_NUM);
  localparam logic [BEAT_W-1:0] BEAT_END  = BEAT_W'(BEATS - 1);
  localparam logic [DLY_W-1:0]  DLY_END   = DLY_W'(RAM_DELAY - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_START, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [AW:0]       wcnt_q, wcnt_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic              cfg_done_q, cfg_done_d;
  logic              ack_q, ack_d;
  logic              ena_q, ena_d;
  logic              wena_q, wena_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [31:0]       dina_q, dina_d;
  logic              start_q, start_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              accept;
`ifdef RSP_PG_CTRL_FRAME_CNT_EN
  logic [15:0]       frame_cnt_q, frame_cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    beat_d  = beat_q;
    dly_d   = dly_q;
    ack_d   = 1'b0;
    ena_d   = 1'b0;
    wena_d  = 1'b0;
    addr_d  = '0;
    dina_d  = '0;
    start_d = 1'b0;
    valid_d = 1'b0;
    last_d  = 1'b0;
    err_d   = 1'b0;
    accept  = (state_q == S_IDLE) && cfg_done_q && ({1'b0, i_frame_entry} < ENTRY_CNT);

    // Table load only happens while idle and not yet complete; the write wins over a request.
    if (state_q == S_IDLE && !cfg_done_q && i_cfg_wr) begin
      ena_d  = 1'b1;
      wena_d = 1'b1;
      addr_d = wcnt_q[AW-1:0];
      dina_d = i_cfg_data;
      wcnt_d = wcnt_q + (AW+1)'(1);
    end
    if (i_frame_req && !accept) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (i_frame_req && accept) begin
          state_d = S_FETCH;
          ack_d   = 1'b1;
          ena_d   = 1'b1;
          addr_d  = i_frame_entry;
        end
      end
      S_FETCH: begin
        state_d = S_WAIT;
        dly_d   = '0;
      end
      S_WAIT: begin
        if (dly_q == DLY_END) begin
          state_d = S_START;
          start_d = 1'b1;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end
      S_START: state_d = S_RUN;
      S_RUN:   if (last_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Beat issue is decided one cycle ahead so the strobes come straight from flops.
    if (state_d == S_RUN && !i_stall) begin
      valid_d = 1'b1;
      last_d  = (beat_q == BEAT_END);
      beat_d  = last_d ? '0 : beat_q + BEAT_W'(1);
    end

    cfg_done_d = (wcnt_d == ENTRY_CNT);
    busy_d     = (state_d != S_IDLE);
`ifdef RSP_PG_CTRL_FRAME_CNT_EN
    frame_cnt_d = frame_cnt_q + 16'(last_d);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      beat_q     <= '0;
      dly_q      <= '0;
      cfg_done_q <= 1'b0;
      ack_q      <= 1'b0;
      ena_q      <= 1'b0;
      wena_q     <= 1'b0;
      addr_q     <= '0;
      dina_q     <= '0;
      start_q    <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef RSP_PG_CTRL_FRAME_CNT_EN
      frame_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      beat_q     <= beat_d;
      dly_q      <= dly_d;
      cfg_done_q <= cfg_done_d;
      ack_q      <= ack_d;
      ena_q      <= ena_d;
      wena_q     <= wena_d;
      addr_q     <= addr_d;
      dina_q     <= dina_d;
      start_q    <= start_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
`ifdef RSP_PG_CTRL_FRAME_CNT_EN
      frame_cnt_q <= frame_cnt_d;
`endif
    end
  end

  assign o_cfg_done   = cfg_done_q;
  assign o_frame_ack  = ack_q;
  assign o_ram1_ena   = ena_q;
  assign o_ram1_wena  = wena_q;
  assign o_ram1_addr  = addr_q;
  assign o_ram1_dina  = dina_q;
  assign o_start      = start_q;
  assign o_data_valid = valid_q;
  assign o_data_last  = last_q;
  assign o_busy       = busy_q;
  assign o_err        = err_q;
`ifdef RSP_PG_CTRL_FRAME_CNT_EN
  assign o_frame_cnt  = frame_cnt_q;
`endif

endmodule

// File: doc/rsp_s1_prep_pg_ctrl.md
RSP_S1_PREP_PG_CTRL -- requirements
Module: rsp_s1_prep_pg_ctrl

Interface
REQ-001 SHALL have parameter RAM_DELAY, default 2, entry-RAM read latency in clk cycles.
REQ-002 SHALL have parameter RAM1_ADDR_WIDTH, default 6, entry-RAM address width.
REQ-003 SHALL have parameter ENTRY_NUM, default 32, number of entry-table words.
REQ-004 SHALL have parameter DATA_NUM, default 1024, samples per frame; LANES fixed at 4, so beats per frame BEATS = DATA_NUM/4.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: clk  in  1  system clock; rst_n  in  1  async active-low reset.
REQ-006 SHALL have i_cfg_wr  in  1  host entry-word write strobe.
REQ-007 SHALL have i_cfg_data  in  32  entry word.
REQ-008 SHALL have o_cfg_done  out  1  all ENTRY_NUM words loaded.
REQ-009 SHALL have i_frame_req  in  1  frame request strobe.
REQ-010 SHALL have i_frame_entry  in  RAM1_ADDR_WIDTH  requested entry index.
REQ-011 SHALL have o_frame_ack  out  1  one-cycle request-accepted pulse.
REQ-012 SHALL have i_stall  in  1  downstream hold.
REQ-013 SHALL have the entry-RAM port: o_ram1_ena  out  1; o_ram1_wena  out  1; o_ram1_addr  out  RAM1_ADDR_WIDTH; o_ram1_dina  out  32.
REQ-014 SHALL have o_start  out  1; o_data_valid  out  1; o_data_last  out  1, the sequencing strobes to the phase-generation datapath.
REQ-015 SHALL have o_busy  out  1  FSM not IDLE; o_err  out  1  one-cycle rejected-request pulse.

Function
REQ-016 SHALL implement states IDLE, FETCH, WAIT, START, RUN; all outputs registered.
REQ-017 SHALL, in IDLE with o_cfg_done=0 and i_cfg_wr=1, drive o_ram1_ena=o_ram1_wena=1, o_ram1_addr=write count and o_ram1_dina=i_cfg_data in the next cycle, then increment the write count.
REQ-018 SHALL assert o_cfg_done when the write count reaches ENTRY_NUM, and hold the count there; i_cfg_wr when o_cfg_done=1 or outside IDLE is ignored.
REQ-019 SHALL, in IDLE with i_cfg_wr=1 and i_frame_req=1 in the same cycle while o_cfg_done=0, perform the write and reject the request.
REQ-020 SHALL accept i_frame_req only in IDLE with o_cfg_done=1 and i_frame_entry<ENTRY_NUM.
REQ-021 SHALL, on a request accepted at cycle T, enter FETCH at T+1 with o_frame_ack=1, o_ram1_ena=1, o_ram1_wena=0 and o_ram1_addr=entry latched at T.
REQ-022 SHALL stay in WAIT for exactly RAM_DELAY cycles, then spend one cycle in START with o_start=1, then enter RUN; with default parameters o_start is high at T+4.
REQ-023 SHALL, in RUN, assert o_data_valid in each cycle with i_stall=0 and advance the beat counter; with i_stall=1, o_data_valid=0 and the counter holds.
REQ-024 SHALL assert o_data_last together with beat BEATS-1 only, then return to IDLE in the next cycle; with defaults and no stall, valid is high T+5..T+260 and last at T+260.
REQ-025 SHALL pulse o_err for one cycle, with no ack, for i_frame_req when o_cfg_done=0, when i_frame_entry>=ENTRY_NUM, or outside IDLE.
REQ-026 SHALL hold o_ram1_ena and o_ram1_wena at 0 in every cycle not covered by REQ-017 and REQ-021.
REQ-027 SHALL assert o_busy in every state except IDLE.

Reset
REQ-028 SHALL, on rst_n=0, asynchronously go to IDLE, clear the write and beat counters, and drive every output to 0.
REQ-029 SHALL, after reset mid-frame or mid-load, require a full ENTRY_NUM-word reload (o_cfg_done=0) before any frame is accepted.

Configuration
REQ-030 SHALL, with RSP_PG_CTRL_FRAME_CNT_EN defined, provide output o_frame_cnt (16 bits, reset 0) that increments on each o_data_last and wraps 0xFFFF->0; without the macro the port and counter do not exist and all other behaviour is identical.

Verification
REQ-031 SHALL cover: 32 i_cfg_wr with data 0x1000_0000+n -> addr 0..31 written, o_cfg_done=1 after the 32nd; a 33rd write produces no RAM activity.
REQ-032 SHALL cover: frame_req entry=5 at T, no stall -> ack and read addr 5 at T+1, o_start at T+4, 256 valids T+5..T+260, last at T+260, o_busy low at T+261.
REQ-033 SHALL cover: i_stall high for 10 cycles mid-RUN -> exactly 256 valids total, last delayed by 10 cycles.
REQ-034 SHALL cover: frame_req before config done, with entry=40, and while busy -> o_err pulse, no ack, state unchanged.
REQ-035 SHALL cover: rst_n low during RUN beat 100 -> all outputs 0 immediately, o_cfg_done=0, and subsequent frame_req -> o_err.
REQ-036 SHALL cover: with RSP_PG_CTRL_FRAME_CNT_EN, 3 back-to-back frames -> o_frame_cnt=3.
